dac_output_tx: RTL
==================

DAC_OUTPUT_TX -- requirements
Module: dac_output_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter DATA_MAX, default 181: upper clip bound for the DAC code; legal range 0..4095.
REQ-003 SHALL have parameter CTRL_BITS, default 4'b0011: DAC command nibble sent ahead of the code.
REQ-004 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port u_in  input  16  signed control value from the PI output stage.
REQ-007 SHALL have port load  input  1  one-cycle strobe requesting transmission of u_in.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-010 SHALL have port dac_cs_n  output  1  DAC chip select, active low.
REQ-011 SHALL have port dac_sclk  output  1  serial clock, SPI mode 0, idle low.
REQ-012 SHALL have port dac_mosi  output  1  serial data, MSB first.
REQ-013 SHALL have port dac_ldac_n  output  1  DAC latch strobe, active low.

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, HOLD, LATCH, with one shared down-counter for phase timing.
REQ-015 SHALL, in IDLE with load=1, capture u_in, enter SETUP on the next edge, and assert busy and dac_cs_n=0 from that cycle.
REQ-016 SHALL ignore load whenever busy=1; no queuing and no restart.
REQ-017 SHALL clip at capture: u_in<0 -> code 0; u_in>DATA_MAX -> code DATA_MAX; otherwise code = u_in[11:0]; comparison signed 16-bit.
REQ-018 SHALL form frame = {CTRL_BITS, code[11:0]}, 16 bits, shifted MSB first.
REQ-019 SHALL hold SETUP for CLK_DIV cycles with sclk=0 and mosi=frame[15].
REQ-020 SHALL, in SHIFT, emit per bit sclk low for CLK_DIV cycles then high for CLK_DIV cycles; mosi changes only on the cycle sclk falls (or at SHIFT entry for bit 15).
REQ-021 SHALL leave SHIFT after the 16th sclk high phase, driving sclk=0 in HOLD.
REQ-022 SHALL hold HOLD for CLK_DIV cycles with dac_cs_n=0, then deassert dac_cs_n on LATCH entry.
REQ-023 SHALL drive dac_ldac_n=0 for exactly CLK_DIV cycles in LATCH, with dac_cs_n=1.
REQ-024 SHALL, on LATCH exit, pulse done for one cycle, drop busy in that same cycle, and return to IDLE.
REQ-025 SHALL give load-to-done latency of 1 + CLK_DIV*(1 + 32 + 1 + 1) cycles (141 for CLK_DIV=4); done on cycle 141 after the load edge.
REQ-026 SHALL accept load in the cycle immediately after done (back-to-back frames, no gap beyond IDLE cycle).
REQ-027 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-028 SHALL, on reset=1 at any time, asynchronously force IDLE, counter 0, busy=0, done=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1.
REQ-029 SHALL, if reset occurs mid-frame, abandon the frame with no done pulse; first load after release starts a fresh frame.

Verification
REQ-030 SHALL cover: load with u_in=100, CLK_DIV=4 -> serial word 0x3064 MSB first, done at cycle 141, ldac_n low 4 cycles.
REQ-031 SHALL cover: u_in=-5 -> code 0, word 0x3000; u_in=181 -> 0x30B5; u_in=32767 -> 0x30B5.
REQ-032 SHALL cover: load pulsed at cycles 10 and 50 of a frame -> ignored; exactly one frame, one done.
REQ-033 SHALL cover: reset asserted during bit 7 of SHIFT -> outputs at reset values same cycle, no done; next load yields complete, correct frame.
REQ-034 SHALL cover: load asserted the cycle after done -> second frame starts, both words correct, cs_n high between frames.
REQ-035 SHALL cover: CLK_DIV=1 -> sclk toggles every cycle, latency 36 cycles, word correct.

Source files
------------

// File: rtl/dac_output_tx.sv
// Serial transmitter that clips a signed PI output to a DAC code and sends it as a
// 16-bit SPI mode-0 frame. The DAC latch strobe (ldac_n) is pulsed after the frame.
module dac_output_tx #(
    parameter int         CLK_DIV   = 4,
    parameter int         DATA_MAX  = 181,
    parameter logic [3:0] CTRL_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] u_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_t;

    localparam logic [7:0]         CNT_INIT = 8'(CLK_DIV - 1);
    localparam logic signed [15:0] CLIP_MAX = 16'(DATA_MAX);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic        r_capt;
    logic [11:0] w_code;

    // Signed clip of the incoming control value into the DAC code range.
    always_comb begin
        w_code = u_in[11:0];
        if ($signed(u_in) < 16'sd0) begin
            w_code = 12'd0;
        end else if ($signed(u_in) > CLIP_MAX) begin
            w_code = CLIP_MAX[11:0];
        end
    end

    // A load is captured in IDLE, and the frame begins on the following edge;
    // r_capt marks that capture cycle so further loads are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 4'd0;
            r_shift    <= 16'd0;
            r_capt     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_capt) begin
                        r_capt   <= 1'b0;
                        r_state  <= SETUP;
                        r_cnt    <= CNT_INIT;
                        busy     <= 1'b1;
                        dac_cs_n <= 1'b0;
                        dac_mosi <= r_shift[15];
                    end else if (load) begin
                        r_capt  <= 1'b1;
                        r_shift <= {CTRL_BITS, w_code};
                    end
                end
                SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNT_INIT;
                        r_bit   <= 4'd15;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                // Each bit is a low phase then a high phase; data advances on the falling edge.
                SHIFT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cnt <= CNT_INIT;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            dac_sclk <= 1'b0;
                            if (r_bit == 4'd0) begin
                                r_state <= HOLD;
                            end else begin
                                r_bit    <= r_bit - 4'd1;
                                r_shift  <= {r_shift[14:0], 1'b0};
                                dac_mosi <= r_shift[14];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= LATCH;
                        r_cnt      <= CNT_INIT;
                        dac_cs_n   <= 1'b1;
                        dac_ldac_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                LATCH: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= IDLE;
                        dac_ldac_n <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
